// File: rtl/bus_gate_arbiter_pkg.sv
// Shared definitions for the bus gate arbiter: FSM encoding,
// index/counter width helper and the masked bus word width.
package bus_gate_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_TURN  = 2'b10
    } state_t;

    localparam int BUS_W = 16;

    // Width needed to hold values 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_gate_arbiter_rr_pick.sv
// Combinational round-robin select: first requester at or after
// the pointer, wrapping from NSRC-1 back to 0.
module bus_gate_arbiter_rr_pick
    import bus_gate_arbiter_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int PW   = idx_w(NSRC)
) (
    input  logic [NSRC-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [PW-1:0]   o_sel,
    output logic            o_any
);

    logic [PW:0] w_sum;

    always_comb begin
        o_sel = '0;
        o_any = 1'b0;
        w_sum = '0;
        for (int k = 0; k < NSRC; k++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NSRC))
                w_sum = w_sum - (PW+1)'(NSRC);
            if (!o_any && i_req[w_sum[PW-1:0]]) begin
                o_any = 1'b1;
                o_sel = w_sum[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Round-robin owner select for the 16-bit source mask gates, with
// one idle turnaround cycle between tenures (break-before-make).
module bus_gate_arbiter
    import bus_gate_arbiter_pkg::*;
#(
    parameter int NSRC     = 4,
    parameter int MAXBEATS = 8
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic [NSRC-1:0]        REQ,
    input  logic [NSRC-1:0]        LAST,
    output logic [NSRC-1:0]        GNT,
    output logic [idx_w(NSRC)-1:0] OWNER,
    output logic                   BUSY,
    output logic                   TMO
);

    localparam int OW = idx_w(NSRC);
    localparam int BW = idx_w(MAXBEATS + 1);

    state_t          r_state;
    logic [NSRC-1:0] r_gnt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_ptr;
    logic [BW-1:0]   r_beat;
    logic            r_busy;
    logic            r_tmo;

    logic [OW-1:0]   w_sel;
    logic            w_any;
    logic            w_own_req;
    logic            w_own_last;
    logic            w_lim;
    logic            w_rel;
    logic [OW-1:0]   w_nxt_ptr;
    logic [NSRC-1:0] w_onehot;

    bus_gate_arbiter_rr_pick #(
        .NSRC (NSRC),
        .PW   (OW)
    ) u_pick (
        .i_req (REQ),
        .i_ptr (r_ptr),
        .o_sel (w_sel),
        .o_any (w_any)
    );

    assign w_own_req  = REQ[r_owner];
    assign w_own_last = LAST[r_owner];
    assign w_lim      = (r_beat == BW'(MAXBEATS));
    assign w_rel      = !w_own_req || w_own_last || w_lim;
    assign w_nxt_ptr  = (r_owner == OW'(NSRC-1)) ? '0 : r_owner + 1'b1;
    assign w_onehot   = {{(NSRC-1){1'b0}}, 1'b1} << w_sel;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_beat  <= '0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_tmo <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_TURN: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= w_onehot;
                        r_owner <= w_sel;
                        r_busy  <= 1'b1;
                        r_beat  <= BW'(1);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (w_rel) begin
                        r_state <= ST_TURN;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_nxt_ptr;
                        // Only a pure limit cut is reported as a timeout
                        r_tmo   <= w_lim && w_own_req && !w_own_last;
                    end else if (!w_lim) begin
                        r_beat  <= r_beat + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        assert ($onehot0(r_gnt));
    end

    assign GNT   = r_gnt;
    assign OWNER = r_owner;
    assign BUSY  = r_busy;
    assign TMO   = r_tmo;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed checks of grant order, turnaround, timeout and async reset,
// plus a randomized soak watched by per-cycle gate-enable checks.
module tb_bus_gate_arbiter;

    logic       CLK;
    logic       RSTn;
    logic [3:0] REQ;
    logic [3:0] LAST;
    logic [3:0] GNT;
    logic [1:0] OWNER;
    logic       BUSY;
    logic       TMO;

    int n_tests = 0;
    int n_fail  = 0;

    bus_gate_arbiter #(
        .NSRC     (4),
        .MAXBEATS (8)
    ) dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .REQ   (REQ),
        .LAST  (LAST),
        .GNT   (GNT),
        .OWNER (OWNER),
        .BUSY  (BUSY),
        .TMO   (TMO)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        REQ  = '0;
        LAST = '0;
        tick();
        tick();
        RSTn = 1'b1;
    endtask

    // Per-cycle watch: one-hot enables, BUSY agreement, no direct handover
    logic [3:0] r_prev_gnt = '0;
    always @(negedge CLK) begin
        if (!RSTn) begin
            r_prev_gnt <= '0;
        end else begin
            n_tests++;
            assert ($countones(GNT) <= 1) else begin
                n_fail++;
                $error("FAIL onehot: observed %0h expected popcount<=1", GNT);
            end
            n_tests++;
            assert (BUSY === (GNT != 4'b0)) else begin
                n_fail++;
                $error("FAIL busy_gnt: observed %0b expected %0b",
                       BUSY, (GNT != 4'b0));
            end
            n_tests++;
            assert (!(r_prev_gnt != 0 && GNT != 0 && r_prev_gnt != GNT)) else begin
                n_fail++;
                $error("FAIL handover: observed %0h expected 0 after %0h",
                       GNT, r_prev_gnt);
            end
            r_prev_gnt <= GNT;
        end
    end

    logic [3:0] exp_g;

    initial begin
        RSTn = 1'b0;
        REQ  = '0;
        LAST = '0;
        tick();
        chk("rst_gnt",   8'(GNT),   8'h0);
        chk("rst_owner", 8'(OWNER), 8'h0);
        chk("rst_busy",  8'(BUSY),  8'h0);
        chk("rst_tmo",   8'(TMO),   8'h0);
        RSTn = 1'b1;

        // 1: sole requester, LAST on beat 3, regrant after turnaround
        REQ = 4'b0100;
        tick();
        chk("t1_b1_gnt",   8'(GNT),   8'h4);
        chk("t1_b1_owner", 8'(OWNER), 8'h2);
        chk("t1_b1_busy",  8'(BUSY),  8'h1);
        tick();
        chk("t1_b2_gnt", 8'(GNT), 8'h4);
        tick();
        chk("t1_b3_gnt", 8'(GNT), 8'h4);
        LAST = 4'b0100;
        tick();
        chk("t1_turn_gnt",  8'(GNT),  8'h0);
        chk("t1_turn_busy", 8'(BUSY), 8'h0);
        chk("t1_turn_tmo",  8'(TMO),  8'h0);
        LAST = 4'b0000;
        tick();
        chk("t1_regnt",       8'(GNT),   8'h4);
        chk("t1_regnt_owner", 8'(OWNER), 8'h2);

        // 2: all requesting, LAST on beat 2 -> owners 0,1,2,3,0
        do_reset();
        REQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            tick();
            chk("t2_b1_gnt",   8'(GNT),   8'(exp_g));
            chk("t2_b1_owner", 8'(OWNER), 8'(i % 4));
            tick();
            chk("t2_b2_gnt", 8'(GNT), 8'(exp_g));
            LAST = 4'b1111;
            tick();
            chk("t2_turn_gnt", 8'(GNT), 8'h0);
            chk("t2_turn_tmo", 8'(TMO), 8'h0);
            LAST = 4'b0000;
        end

        // 3: tenure cut by the beat limit
        do_reset();
        REQ = 4'b0010;
        for (int b = 1; b <= 8; b++) begin
            tick();
            chk("t3_beat_gnt", 8'(GNT), 8'h2);
            chk("t3_beat_tmo", 8'(TMO), 8'h0);
        end
        tick();
        chk("t3_cut_gnt",  8'(GNT),  8'h0);
        chk("t3_cut_tmo",  8'(TMO),  8'h1);
        chk("t3_cut_busy", 8'(BUSY), 8'h0);
        tick();
        chk("t3_regnt_gnt", 8'(GNT), 8'h2);
        chk("t3_regnt_tmo", 8'(TMO), 8'h0);

        // 4: owner drops request mid-tenure while source 0 waits
        do_reset();
        REQ = 4'b0100;
        tick();
        chk("t4_b1_gnt", 8'(GNT), 8'h4);
        tick();
        REQ = 4'b0101;
        tick();
        chk("t4_b3_gnt", 8'(GNT), 8'h4);
        REQ = 4'b0001;
        tick();
        chk("t4_drop_gnt", 8'(GNT), 8'h0);
        chk("t4_drop_tmo", 8'(TMO), 8'h0);
        tick();
        chk("t4_new_gnt",   8'(GNT),   8'h1);
        chk("t4_new_owner", 8'(OWNER), 8'h0);
        chk("t4_new_tmo",   8'(TMO),   8'h0);

        // 5: asynchronous reset in the middle of a tenure
        do_reset();
        REQ = 4'b0100;
        tick();
        chk("t5_pre_gnt", 8'(GNT), 8'h4);
        #2;
        RSTn = 1'b0;
        #1;
        chk("t5_async_gnt",  8'(GNT),  8'h0);
        chk("t5_async_busy", 8'(BUSY), 8'h0);
        tick();
        chk("t5_rst_owner", 8'(OWNER), 8'h0);
        RSTn = 1'b1;
        REQ  = 4'b1000;
        tick();
        chk("t5_gnt",   8'(GNT),   8'h8);
        chk("t5_owner", 8'(OWNER), 8'h3);
        chk("t5_busy",  8'(BUSY),  8'h1);

        // 6: random soak, checked by the per-cycle watch
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            REQ  = 4'($urandom);
            LAST = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            tick();
        end
        REQ  = '0;
        LAST = '0;
        tick();
        tick();
        tick();
        chk("t6_idle_gnt", 8'(GNT), 8'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
